// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage RV32I core.
// Holds the decoded instruction for EX and detects load-use hazards against the ID instruction.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [7:0]       id_ctrl,
  input  logic [3:0]       id_alu_op,
  input  logic             ext_stall,
  input  logic             flush,
  output logic             hazard_stall,
  output logic             id_ex_valid,
  output logic [XLEN-1:0]  id_ex_pc,
  output logic [XLEN-1:0]  id_ex_rs1_data,
  output logic [XLEN-1:0]  id_ex_rs2_data,
  output logic [XLEN-1:0]  id_ex_imm,
  output logic [4:0]       id_ex_rs1,
  output logic [4:0]       id_ex_rs2,
  output logic [4:0]       id_ex_rd,
  output logic [7:0]       id_ex_ctrl,
  output logic [3:0]       id_ex_alu_op,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [7:0]      ctrl;
    logic [3:0]      alu_op;
  } stage_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  stage_t stage_q;
  stage_t stage_d;
  logic   load_use;

  // A load in EX cannot forward to ID's consumer; an all-zero bubble never matches forwarding.
  assign load_use = stage_q.valid && stage_q.ctrl[1] && (stage_q.rd != 5'd0) && id_valid &&
                    ((id_uses_rs1 && (id_rs1 == stage_q.rd)) ||
                     (id_uses_rs2 && (id_rs2 == stage_q.rd)));

  assign hazard_stall = load_use && !flush;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    stage_d = '0;
    if (id_valid) begin
      stage_d.valid    = 1'b1;
      stage_d.pc       = id_pc;
      stage_d.rs1_data = id_rs1_data;
      stage_d.rs2_data = id_rs2_data;
      stage_d.imm      = id_imm;
      stage_d.rs1      = id_rs1;
      stage_d.rs2      = id_rs2;
      stage_d.rd       = id_rd;
      stage_d.ctrl     = id_ctrl;
      stage_d.alu_op   = id_alu_op;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q     <= '0;
      stall_count <= '0;
      flush_count <= '0;
    end else if (flush) begin
      stage_q <= '0;
      if (flush_count != CNT_MAX) flush_count <= flush_count + CNT_W'(1);
    end else if (!ext_stall) begin
      if (hazard_stall) begin
        stage_q <= '0;
        if (stall_count != CNT_MAX) stall_count <= stall_count + CNT_W'(1);
      end else begin
        stage_q <= stage_d;
      end
    end
  end

  assign id_ex_valid    = stage_q.valid;
  assign id_ex_pc       = stage_q.pc;
  assign id_ex_rs1_data = stage_q.rs1_data;
  assign id_ex_rs2_data = stage_q.rs2_data;
  assign id_ex_imm      = stage_q.imm;
  assign id_ex_rs1      = stage_q.rs1;
  assign id_ex_rs2      = stage_q.rs2;
  assign id_ex_rd       = stage_q.rd;
  assign id_ex_ctrl     = stage_q.ctrl;
  assign id_ex_alu_op   = stage_q.alu_op;

endmodule
